// File: rtl/cpu5_store_buffer_if.sv
// Core/memory-side bus of the cpu5 store buffer: core store/load port plus memory write/read port.
interface cpu5_store_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            core_memwrite;
    logic [XLEN-1:0] core_addr;
    logic [XLEN-1:0] core_wdata;
    logic [XLEN-1:0] core_rdata;
    logic            stall;
    logic            empty;
    logic            mem_req;
    logic [XLEN-1:0] mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_raddr;
    logic [XLEN-1:0] mem_rdata;

    // Environment view: drives core requests and memory responses
    modport master (
        output core_memwrite, core_addr, core_wdata, mem_ack, mem_rdata,
        input  core_rdata, stall, empty, mem_req, mem_waddr, mem_wdata, mem_raddr
    );

    // Buffer view
    modport slave (
        input  core_memwrite, core_addr, core_wdata, mem_ack, mem_rdata,
        output core_rdata, stall, empty, mem_req, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/cpu5_store_buffer.sv
// Posted-write store buffer: FIFO of full-word stores drained over a req/ack write port,
// with store-to-load forwarding from the youngest matching pending entry.
module cpu5_store_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    cpu5_store_buffer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;

    logic [XLEN-1:0] addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;

    logic            full;
    logic            none;
    logic            enq;
    logic            deq;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    ptr_t            fwd_idx;

    // Flags derive from registered count only, so stall has no path from mem_ack
    assign full = (count_q == cnt_t'(DEPTH));
    assign none = (count_q == '0);
    assign enq  = bus.core_memwrite && !full;
    assign deq  = bus.mem_ack && !none;

    assign bus.stall     = full;
    assign bus.empty     = none;
    assign bus.mem_req   = !none;
    assign bus.mem_waddr = addr_q[rd_ptr_q];
    assign bus.mem_wdata = data_q[rd_ptr_q];
    assign bus.mem_raddr = bus.core_addr;

    // Next-state for pointers and occupancy; enqueue and dequeue may coincide
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        count_d = count_q + cnt_t'(enq) - cnt_t'(deq);
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only read while counted valid, so no reset needed
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= bus.core_addr;
            data_q[wr_ptr_q] <= bus.core_wdata;
        end
    end

    // Forwarding: walk entries oldest to youngest so the youngest hit wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = rd_ptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + ptr_t'(i);
            if ((cnt_t'(i) < count_q) &&
                (addr_q[fwd_idx][XLEN-1:2] == bus.core_addr[XLEN-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign bus.core_rdata = fwd_hit ? fwd_data : bus.mem_rdata;
endmodule

// File: tb/tb_cpu5_store_buffer.sv
// Self-checking bench for cpu5_store_buffer against a queue-based reference model.
module tb_cpu5_store_buffer;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic clk;
    logic reset;

    cpu5_store_buffer_if #(.XLEN(XLEN)) bus ();

    cpu5_store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_cmp;
    int unsigned n_err;

    entry_t      q[$];
    logic [31:0] dut_mem [1024];
    logic [31:0] ref_mem [1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Youngest pending store to the same word wins, else memory
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [31:0] mval);
        for (int i = int'(q.size()) - 1; i >= 0; i--) begin
            if (q[i].addr[31:2] == a[31:2]) return q[i].data;
        end
        return mval;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, "_req"},   {31'd0, bus.mem_req}, {31'd0, q.size() != 0});
        check_eq({tag, "_stall"}, {31'd0, bus.stall},   {31'd0, q.size() == DEPTH});
        check_eq({tag, "_empty"}, {31'd0, bus.empty},   {31'd0, q.size() == 0});
        if (q.size() != 0) begin
            check_eq({tag, "_waddr"}, bus.mem_waddr, q[0].addr);
            check_eq({tag, "_wdata"}, bus.mem_wdata, q[0].data);
        end
    endtask

    // One clock: apply inputs, let memory and model react at the edge, check afterwards
    task automatic cycle(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic ack);
        logic m_stall;
        bus.core_memwrite = we;
        bus.core_addr     = a;
        bus.core_wdata    = d;
        bus.mem_ack       = ack;
        bus.mem_rdata     = dut_mem[a[11:2]];
        #1;
        if (bus.mem_req && ack) dut_mem[bus.mem_waddr[11:2]] = bus.mem_wdata;
        m_stall = (q.size() == DEPTH);
        if (ack && q.size() != 0) begin
            ref_mem[q[0].addr[11:2]] = q[0].data;
            void'(q.pop_front());
        end
        if (we && !m_stall) q.push_back('{addr: a, data: d});
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic load_check(input string tag, input logic [31:0] a,
                              input logic [31:0] drive, input logic [31:0] fallback);
        bus.core_memwrite = 1'b0;
        bus.core_addr     = a;
        bus.mem_rdata     = drive;
        #1;
        check_eq({tag, "_raddr"}, bus.mem_raddr, a);
        check_eq({tag, "_rdata"}, bus.core_rdata, model_load(a, fallback));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) begin
            dut_mem[i] = 32'hC0DE_0000 | i;
            ref_mem[i] = 32'hC0DE_0000 | i;
        end
        bus.core_memwrite = 1'b0;
        bus.core_addr     = '0;
        bus.core_wdata    = '0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = '0;

        // Reset pulse
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        check_eq("rst_stall", {31'd0, bus.stall},   32'd0);
        check_eq("rst_empty", {31'd0, bus.empty},   32'd1);

        // Single store, memory ready
        cycle("single_enq", 1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
        check_eq("single_waddr", bus.mem_waddr, 32'h100);
        check_eq("single_wdata", bus.mem_wdata, 32'hDEADBEEF);
        cycle("single_drain", 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("single_empty", {31'd0, bus.empty}, 32'd1);

        // Fill to full, hold the fifth store, release one slot
        for (int i = 0; i < 4; i++) begin
            cycle("fill", 1'b1, 32'h10 + 32'(4 * i), 32'hF000_0000 + 32'(i), 1'b0);
        end
        check_eq("fill_stall", {31'd0, bus.stall}, 32'd1);
        cycle("fill_held", 1'b1, 32'h20, 32'hF000_0004, 1'b0);
        check_eq("fill_held_waddr", bus.mem_waddr, 32'h10);
        cycle("fill_ack", 1'b1, 32'h20, 32'hF000_0004, 1'b1);
        check_eq("fill_unstall", {31'd0, bus.stall}, 32'd0);
        cycle("fill_fifth", 1'b1, 32'h20, 32'hF000_0004, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq("fill_order", bus.mem_waddr, 32'h14 + 32'(4 * i));
            cycle("fill_drain", 1'b0, 32'h0, 32'h0, 1'b1);
        end
        check_eq("fill_done", {31'd0, bus.empty}, 32'd1);

        // Forwarding from the youngest of two stores to the same word
        cycle("fwd_st1", 1'b1, 32'h40, 32'd1, 1'b0);
        cycle("fwd_st2", 1'b1, 32'h40, 32'd2, 1'b0);
        load_check("fwd_40", 32'h40, 32'h1234_5678, 32'h1234_5678);
        check_eq("fwd_young", bus.core_rdata, 32'd2);
        load_check("fwd_44", 32'h44, 32'h1234_5678, 32'h1234_5678);
        check_eq("fwd_miss", bus.core_rdata, 32'h1234_5678);
        load_check("fwd_42", 32'h42, 32'h1234_5678, 32'h1234_5678);
        check_eq("fwd_lowbits", bus.core_rdata, 32'd2);
        cycle("fwd_drain", 1'b0, 32'h0, 32'h0, 1'b1);
        cycle("fwd_drain", 1'b0, 32'h0, 32'h0, 1'b1);

        // Continuous stores with memory always ready: pointers wrap, never stall
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle("wrap", 1'b1, 32'h80 + 32'(4 * i), 32'hAB00_0000 + 32'(i), 1'b1);
            check_eq("wrap_nostall", {31'd0, bus.stall}, 32'd0);
        end
        cycle("wrap_drain", 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset in the middle of a drain discards everything
        for (int i = 0; i < 3; i++) begin
            cycle("mid_fill", 1'b1, 32'hC0 + 32'(4 * i), 32'h5500_0000 + 32'(i), 1'b0);
        end
        cycle("mid_drain", 1'b0, 32'h0, 32'h0, 1'b1);
        bus.mem_ack = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_req",   {31'd0, bus.mem_req}, 32'd0);
        check_eq("mid_rst_empty", {31'd0, bus.empty},   32'd1);
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        cycle("post_rst", 1'b0, 32'h0, 32'h0, 1'b1);

        // Random stores, acks and loads against the model
        for (int i = 0; i < 400; i++) begin
            a = 32'h300 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            load_check("rnd_load", a, dut_mem[a[11:2]], ref_mem[a[11:2]]);
            a = 32'h300 + 32'(4 * $urandom_range(0, 7));
            d = $urandom;
            cycle("rnd", 1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cycle("final_drain", 1'b0, 32'h0, 32'h0, 1'b1);
        end
        check_eq("final_empty", {31'd0, bus.empty}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("mem_image", dut_mem[32'hC0 + i], ref_mem[32'hC0 + i]);
            a = 32'h300 + 32'(4 * i);
            load_check("final_load", a, dut_mem[a[11:2]], ref_mem[a[11:2]]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
